// File: rtl/synapse_current.sv
// synapse_current: four-synapse current accumulator with periodic leak.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   w_we/w_addr/w_data  write one of four signed 8-bit weights
//   spk_valid/spk_idx   incoming spike event and its synapse index
//   spk_ready        high on ACCUM cycles, low on the DECAY cycle and in reset
//   sat_clr          clears the sticky saturation flag
//   I_syn            signed 8-bit synaptic current
//   sat              sticky: an accumulate result was clamped
//
// A free-running counter marks every DECAY_PERIOD-th cycle as the DECAY
// cycle, where the current leaks by I_syn >>> DECAY_SHIFT. Every other cycle
// may accept one spike, which adds the selected weight with saturation.
module synapse_current #(
  parameter int unsigned DECAY_PERIOD = 16,
  parameter int unsigned DECAY_SHIFT  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       w_we,
  input  logic [1:0] w_addr,
  input  logic [7:0] w_data,
  input  logic       spk_valid,
  input  logic [1:0] spk_idx,
  output logic       spk_ready,
  input  logic       sat_clr,
  output logic [7:0] I_syn,
  output logic       sat
);

  localparam logic [7:0] LastCnt = 8'(DECAY_PERIOD - 1);

  logic        [7:0] cnt_q, cnt_d;
  logic signed [7:0] weight_q [4];
  logic signed [7:0] isyn_q, isyn_d;
  logic              sat_q, sat_d;

  logic              is_decay;
  logic              accept;
  logic signed [7:0] w_sel;
  logic signed [8:0] sum;
  logic signed [7:0] decay_val;
  logic              clamped;

  assign is_decay  = (cnt_q == LastCnt);
  // Gate with rst_n so ready drops immediately while reset is held.
  assign spk_ready = rst_n & ~is_decay;
  assign accept    = spk_valid & spk_ready;
  assign cnt_d     = is_decay ? 8'd0 : cnt_q + 8'd1;

  // Old weight is read here; a same-cycle write only lands at the edge.
  assign w_sel     = weight_q[spk_idx];
  assign sum       = {isyn_q[7], isyn_q} + {w_sel[7], w_sel};
  // x - (x >>> s) can never leave the 8-bit range, so no clamp.
  assign decay_val = isyn_q - (isyn_q >>> DECAY_SHIFT);

  always_comb begin
    isyn_d  = isyn_q;
    clamped = 1'b0;
    if (is_decay) begin
      isyn_d = decay_val;
    end else if (accept) begin
      if (sum > 9'sd127) begin
        isyn_d  = 8'sd127;
        clamped = 1'b1;
      end else if (sum < -9'sd128) begin
        isyn_d  = -8'sd128;
        clamped = 1'b1;
      end else begin
        isyn_d = sum[7:0];
      end
    end
  end

  // A clamp wins over a simultaneous clear.
  assign sat_d = (sat_q & ~sat_clr) | clamped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 8'd0;
      isyn_q <= 8'sd0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      isyn_q <= isyn_d;
      sat_q  <= sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) weight_q[i] <= 8'sd0;
    end else if (w_we) begin
      weight_q[w_addr] <= w_data;
    end
  end

  assign I_syn = isyn_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_synapse_current.sv
module tb_synapse_current;

  localparam int Period = 16;
  localparam int Shift  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_we = 1'b0;
  logic [1:0] w_addr = 2'd0;
  logic [7:0] w_data = 8'd0;
  logic       spk_valid = 1'b0;
  logic [1:0] spk_idx = 2'd0;
  logic       spk_ready;
  logic       sat_clr = 1'b0;
  logic [7:0] i_syn;
  logic       sat;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, kept as plain integers.
  int m_cnt, m_isyn, m_sat;
  int m_w [4];

  synapse_current #(.DECAY_PERIOD(Period), .DECAY_SHIFT(Shift)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .spk_valid (spk_valid),
    .spk_idx   (spk_idx),
    .spk_ready (spk_ready),
    .sat_clr   (sat_clr),
    .I_syn     (i_syn),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we; int addr; int data; bit valid; int idx; bit clr;
    int exp_ready; int exp_isyn; int exp_sat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_div(input int v, input int d);
    int q;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_isyn = 0; m_sat = 0;
    for (int i = 0; i < 4; i++) m_w[i] = 0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input bit we, input int addr, input int data, input bit valid,
                       input int idx, input bit clr, input string tag);
    int s;
    bit clamp;
    w_we = we; w_addr = 2'(addr); w_data = 8'(data);
    spk_valid = valid; spk_idx = 2'(idx); sat_clr = clr;
    #1;
    chk({tag, " ready"}, int'(spk_ready), (m_cnt == Period - 1) ? 0 : 1);
    clamp = 0;
    if (m_cnt == Period - 1) begin
      m_isyn = m_isyn - floor_div(m_isyn, 1 << Shift);
    end else if (valid) begin
      s = m_isyn + m_w[idx];
      if (s > 127) begin s = 127; clamp = 1; end
      if (s < -128) begin s = -128; clamp = 1; end
      m_isyn = s;
    end
    if (clamp) m_sat = 1;
    else if (clr) m_sat = 0;
    if (we) m_w[addr] = (data > 127) ? data - 256 : data;
    m_cnt = (m_cnt + 1) % Period;
    @(posedge clk);
    #1;
    chk({tag, " I_syn"}, int'($signed(i_syn)), m_isyn);
    chk({tag, " sat"}, int'(sat), m_sat);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    w_we = 0; spk_valid = 0; sat_clr = 0;
    model_reset();
    #1;
    chk("reset I_syn", int'($signed(i_syn)), 0);
    chk("reset sat", int'(sat), 0);
    chk("reset ready", int'(spk_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs [$];
  int dec_in  [4] = '{100, -100, -1, 1};
  int dec_out [4] = '{75, -75, 0, 1};

  initial begin
    // Sequence starting at counter 0 after reset.
    vecs = '{
      '{1, 1, 40,   0, 0, 0, 1, 0,    0},  // c0 w1=40
      '{0, 0, 0,    1, 1, 0, 1, 40,   0},  // c1
      '{0, 0, 0,    1, 1, 0, 1, 80,   0},  // c2
      '{0, 0, 0,    1, 1, 0, 1, 120,  0},  // c3
      '{1, 0, 100,  0, 0, 0, 1, 120,  0},  // c4 w0=100
      '{0, 0, 0,    1, 0, 0, 1, 127,  1},  // c5 clamp
      '{0, 0, 0,    1, 0, 0, 1, 127,  1},  // c6
      '{0, 0, 0,    0, 0, 1, 1, 127,  0},  // c7 clear
      '{1, 2, 128,  0, 0, 0, 1, 127,  0},  // c8 w2=-128
      '{0, 0, 0,    1, 2, 0, 1, -1,   0},  // c9
      '{0, 0, 0,    1, 2, 0, 1, -128, 1},  // c10 clamp
      '{0, 0, 0,    1, 2, 1, 1, -128, 1},  // c11 clamp beats clear
      '{0, 0, 0,    0, 0, 0, 1, -128, 1},  // c12
      '{0, 0, 0,    0, 0, 0, 1, -128, 1},  // c13
      '{0, 0, 0,    0, 0, 0, 1, -128, 1},  // c14
      '{0, 0, 0,    1, 1, 0, 0, -96,  1},  // c15 decay, spike held off
      '{0, 0, 0,    1, 1, 0, 1, -56,  1}   // c0 spike accepted
    };

    do_reset();
    foreach (vecs[i]) begin
      w_we = vecs[i].we; w_addr = 2'(vecs[i].addr); w_data = 8'(vecs[i].data);
      spk_valid = vecs[i].valid; spk_idx = 2'(vecs[i].idx); sat_clr = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d ready", i), int'(spk_ready), vecs[i].exp_ready);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d I_syn", i), int'($signed(i_syn)), vecs[i].exp_isyn);
      chk($sformatf("vec%0d sat", i), int'(sat), vecs[i].exp_sat);
    end

    // Decay arithmetic on both signs and around zero.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      cycle(1, 0, dec_in[k], 0, 0, 0, "dec wr");
      cycle(0, 0, 0, 1, 0, 0, "dec load");
      chk("dec preload", int'($signed(i_syn)), dec_in[k]);
      repeat (Period - 3) idle("dec idle");
      idle("dec tick");
      chk($sformatf("decay %0d", dec_in[k]), int'($signed(i_syn)), dec_out[k]);
    end

    // Same-cycle write and spike use the old weight.
    do_reset();
    cycle(1, 3, 10, 0, 0, 0, "wsame wr");
    cycle(1, 3, 50, 1, 3, 0, "wsame both");
    chk("write+spike old weight", int'($signed(i_syn)), 10);
    cycle(0, 0, 0, 1, 3, 0, "wsame next");
    chk("new weight applied", int'($signed(i_syn)), 60);

    // Asynchronous reset mid-accumulate with I_syn=57, sat=1.
    do_reset();
    cycle(1, 0, 127, 0, 0, 0, "ar w0");
    cycle(0, 0, 0, 1, 0, 0, "ar s0");
    cycle(0, 0, 0, 1, 0, 0, "ar s1");
    cycle(1, 1, 8'(-70), 0, 0, 0, "ar w1");
    cycle(0, 0, 0, 1, 1, 0, "ar s2");
    chk("pre-reset I_syn", int'($signed(i_syn)), 57);
    chk("pre-reset sat", int'(sat), 1);
    spk_valid = 1; spk_idx = 2'd0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async I_syn", int'($signed(i_syn)), 0);
    chk("async sat", int'(sat), 0);
    chk("async ready", int'(spk_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, k, 0, "weight cleared");
    chk("weights zero after reset", int'($signed(i_syn)), 0);

    // Randomised traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
